// File: rtl/tdm_demux2.sv
// tdm_demux2: splits a two-slot time-multiplexed word stream into registered slot-0 and slot-1 outputs,
// tracking frame alignment from the sync marker and counting complete frames.
module tdm_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic             vld0,
  output logic             vld1,
  output logic             pair_valid,
  output logic             sync_err,
  output logic [7:0]       frame_cnt
);
  typedef enum logic [1:0] {HUNT, EXP1, EXP0} state_t;
  state_t state, state_nx;
  logic cap0, cap1, err;
  always_comb begin
    state_nx = state;
    cap0 = 1'b0;
    cap1 = 1'b0;
    err = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          cap0 = sync;
          state_nx = sync ? EXP1 : HUNT;
        end
        EXP1: begin
          cap0 = sync;
          cap1 = !sync;
          err = sync;
          state_nx = sync ? EXP1 : EXP0;
        end
        EXP0: begin
          cap0 = sync;
          err = !sync;
          state_nx = sync ? EXP1 : HUNT;
        end
        default: state_nx = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
      dout0 <= '0;
      dout1 <= '0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
      pair_valid <= 1'b0;
      sync_err <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      vld0 <= cap0;
      vld1 <= cap1;
      pair_valid <= cap1;
      sync_err <= err;
      if (cap0) dout0 <= din;
      if (cap1) dout1 <= din;
      if (cap1) frame_cnt <= frame_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2: randomized and directed stimulus; a frame-level reference model queues expected outputs
// per cycle and a separate monitor pops and compares them against the DUT.
module tb_tdm_demux2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] dout0, dout1, frame_cnt;
  logic       vld0, vld1, pair_valid, sync_err;
  typedef struct {
    logic [7:0] d0, d1, fc;
    logic       v0, v1, pv, se;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int checks = 0, passes = 0, pv_cnt = 0;
  logic [7:0] m_d0, m_d1, m_fc;
  bit m_have0, m_aligned;
  tdm_demux2 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .dout0(dout0), .dout1(dout1), .vld0(vld0), .vld1(vld1),
    .pair_valid(pair_valid), .sync_err(sync_err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask
  // Model: a frame is "open" after a slot-0 word until its slot-1 word; "aligned" once any sync was seen.
  task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    rst_n = r; din_valid = v; sync = s; din = d;
    x.v0 = 0; x.v1 = 0; x.pv = 0; x.se = 0;
    if (!r) begin
      m_d0 = 0; m_d1 = 0; m_fc = 0; m_have0 = 0; m_aligned = 0;
    end else if (v && s) begin
      x.se = m_have0;
      x.v0 = 1; m_d0 = d; m_have0 = 1; m_aligned = 1;
    end else if (v && m_have0) begin
      x.v1 = 1; x.pv = 1; m_d1 = d; m_fc = m_fc + 8'd1; m_have0 = 0;
    end else if (v && m_aligned) begin
      x.se = 1; m_aligned = 0;
    end
    x.d0 = m_d0; x.d1 = m_d1; x.fc = m_fc;
    sbq.push_back(x);
  endtask
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("dout0", dout0, e.d0);
      chk("dout1", dout1, e.d1);
      chk("frame_cnt", frame_cnt, e.fc);
      chk("vld0", {7'd0, vld0}, {7'd0, e.v0});
      chk("vld1", {7'd0, vld1}, {7'd0, e.v1});
      chk("pair_valid", {7'd0, pair_valid}, {7'd0, e.pv});
      chk("sync_err", {7'd0, sync_err}, {7'd0, e.se});
      chk("vld_excl", {7'd0, vld0 & vld1}, 8'd0);
      if (pair_valid) pv_cnt++;
    end
  end
  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain", (sbq.size() > 0) ? 8'd1 : 8'd0, 8'd0);
  endtask
  initial begin
    int pv0;
    drive(0, 0, 0, 8'h00);
    drive(0, 1, 1, 8'hEE);
    // normal frame
    drive(1, 1, 1, 8'h11);
    drive(1, 1, 0, 8'h22);
    drive(1, 0, 0, 8'h00);
    drain();
    chk("normal_cnt", frame_cnt, 8'd1);
    // hunt
    drive(0, 0, 0, 8'h00);
    drive(1, 1, 0, 8'h33);
    drive(1, 1, 0, 8'h44);
    drive(1, 0, 1, 8'h99);
    // early resync
    drive(0, 0, 0, 8'h00);
    drive(1, 1, 1, 8'h55);
    drive(1, 1, 1, 8'h66);
    drive(1, 1, 0, 8'h77);
    // lost alignment
    drive(1, 1, 0, 8'h88);
    drive(1, 1, 0, 8'h89);
    drive(1, 0, 0, 8'h00);
    drain();
    chk("resync_d1", dout1, 8'h77);
    chk("resync_d0", dout0, 8'h66);
    // reset mid-frame
    drive(1, 1, 1, 8'hAA);
    drive(0, 1, 0, 8'hCC);
    drive(1, 1, 0, 8'hBB);
    drive(1, 0, 0, 8'h00);
    drain();
    chk("rst_mid_d0", dout0, 8'h00);
    chk("rst_mid_d1", dout1, 8'h00);
    // 256 frames with gaps and spurious sync while idle
    drive(0, 0, 0, 8'h00);
    pv0 = pv_cnt;
    for (int f = 0; f < 256; f++) begin
      repeat ($urandom_range(0, 2)) drive(1, 0, 1'($urandom_range(0, 1)), 8'($urandom));
      drive(1, 1, 1, 8'($urandom));
      repeat ($urandom_range(0, 2)) drive(1, 0, 1'($urandom_range(0, 1)), 8'($urandom));
      drive(1, 1, 0, 8'($urandom));
    end
    drive(1, 0, 0, 8'h00);
    drain();
    chk("wrap_pulses", 8'(pv_cnt - pv0), 8'd0);
    chk("wrap_pulses_nz", (pv_cnt - pv0 == 256) ? 8'd1 : 8'd0, 8'd1);
    chk("wrap_cnt", frame_cnt, 8'd0);
    // fully random traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
    drive(1, 0, 0, 8'h00);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
